// File: rtl/uart_pkt_parser.sv
// Byte-stream frame parser: SOF, LEN, payload, XOR check. It buffers the payload
// and replays it on a valid/ready/last stream only once the check byte matches.
module uart_pkt_parser #(
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 104_170
) (
  input  logic       clk_i,
  input  logic       aresetn_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       m_last_o,
  output logic       pkt_ok_o,
  output logic       pkt_err_o,
  output logic [1:0] err_code_o
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DRAIN} state_t;
  typedef enum logic [1:0] {E_NONE, E_BAD_LEN, E_BAD_CHK, E_TIMEOUT} err_t;

  localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int               TMO_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

  state_t           r_state, w_next;
  logic             r_rdy;
  logic [7:0]       r_len, r_chk, r_cnt, r_rd;
  logic [7:0]       r_buf [MAX_LEN];
  logic [TMO_W-1:0] r_tmo;
  logic             r_ok, r_err;
  logic [1:0]       r_err_code;

  logic             w_acc, w_len_bad, w_data_last, w_rd_last, w_m_hs, w_tmo_hit;
  logic             w_ok, w_err;
  err_t             w_code;

  // r_rdy holds s_ready_o low until the first edge after reset releases.
  assign s_ready_o   = r_rdy && (r_state != S_DRAIN);
  assign w_acc       = s_valid_i && s_ready_o;
  assign w_len_bad   = (s_data_i == 8'd0) || (s_data_i > MAX_LEN_B);
  assign w_data_last = (r_cnt == r_len - 8'd1);
  assign w_rd_last   = (r_rd == r_len - 8'd1);
  assign w_tmo_hit   = (r_tmo == TMO_LAST);

  assign m_valid_o   = (r_state == S_DRAIN);
  assign m_last_o    = m_valid_o && w_rd_last;
  assign m_data_o    = m_valid_o ? r_buf[r_rd[IDX_W-1:0]] : 8'd0;
  assign w_m_hs      = m_valid_o && m_ready_i;

  assign pkt_ok_o    = r_ok;
  assign pkt_err_o   = r_err;
  assign err_code_o  = r_err_code;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    w_ok   = 1'b0;
    w_err  = 1'b0;
    w_code = E_NONE;
    unique case (r_state)
      S_IDLE: if (w_acc && s_data_i == SOF_BYTE) w_next = S_LEN;
      S_LEN: begin
        if (w_acc) begin
          if (w_len_bad) begin
            w_err  = 1'b1;
            w_code = E_BAD_LEN;
            w_next = S_IDLE;
          end else begin
            w_next = S_DATA;
          end
        end else if (w_tmo_hit) begin
          w_err  = 1'b1;
          w_code = E_TIMEOUT;
          w_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_acc) begin
          if (w_data_last) w_next = S_CHK;
        end else if (w_tmo_hit) begin
          w_err  = 1'b1;
          w_code = E_TIMEOUT;
          w_next = S_IDLE;
        end
      end
      S_CHK: begin
        if (w_acc) begin
          if (s_data_i == r_chk) begin
            w_ok   = 1'b1;
            w_next = S_DRAIN;
          end else begin
            w_err  = 1'b1;
            w_code = E_BAD_CHK;
            w_next = S_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err  = 1'b1;
          w_code = E_TIMEOUT;
          w_next = S_IDLE;
        end
      end
      S_DRAIN: if (w_m_hs && w_rd_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_rdy      <= 1'b0;
      r_len      <= 8'd0;
      r_chk      <= 8'd0;
      r_cnt      <= 8'd0;
      r_rd       <= 8'd0;
      r_tmo      <= '0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_rdy <= 1'b1;
      r_ok  <= w_ok;
      r_err <= w_err;
      if (w_err) r_err_code <= w_code;

      if (w_acc && r_state == S_LEN && !w_len_bad) begin
        r_len <= s_data_i;
        r_chk <= s_data_i;
        r_cnt <= 8'd0;
      end
      if (w_acc && r_state == S_DATA) begin
        r_chk <= r_chk ^ s_data_i;
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_ok)        r_rd <= 8'd0;
      else if (w_m_hs) r_rd <= r_rd + 8'd1;

      // Idle-clock count only runs while waiting for a byte inside a frame.
      if (w_acc || (w_next != r_state) || r_state == S_IDLE || r_state == S_DRAIN)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  // NOTE: the payload buffer has no reset; every entry read in DRAIN has been
  // written earlier in the same frame, so its power-up value never escapes.
  always_ff @(posedge clk_i) begin
    if (w_acc && r_state == S_DATA) r_buf[r_cnt[IDX_W-1:0]] <= s_data_i;
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: a table of whole frames with expected
// pulses, error code and payload, plus sequences for stall, timeout and reset.
module tb_uart_pkt_parser;

  logic       clk_i = 1'b0;
  logic       aresetn_i = 1'b0;
  logic [7:0] s_data_i = 8'd0;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b1;
  logic       m_last_o;
  logic       pkt_ok_o;
  logic       pkt_err_o;
  logic [1:0] err_code_o;

  uart_pkt_parser #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(50)) dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_last_o(m_last_o), .pkt_ok_o(pkt_ok_o), .pkt_err_o(pkt_err_o),
    .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Passive monitor; the main thread only reads these, taking deltas.
  int         ok_cnt = 0, err_cnt = 0, both_cnt = 0, stray_last = 0;
  logic [8:0] outq[$];

  always @(negedge clk_i) begin
    if (aresetn_i) begin
      if (pkt_ok_o) ok_cnt++;
      if (pkt_err_o) err_cnt++;
      if (pkt_ok_o && pkt_err_o) both_cnt++;
      if (m_last_o && !m_valid_o) stray_last++;
      if (m_valid_o && m_ready_i) outq.push_back({m_last_o, m_data_o});
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk_i);
    s_data_i  = b;
    s_valid_i = 1'b1;
    n = 0;
    while (!s_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("send_ready", 32'(s_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic check_outs(input string name, input int q0, input int n_out,
                            input logic [7:0] exp_data[16]);
    check({name, "_count"}, 32'(outq.size() - q0), 32'(n_out));
    for (int j = 0; j < n_out; j++) begin
      if (q0 + j < outq.size()) begin
        check({name, "_data"}, 32'(outq[q0+j][7:0]), 32'(exp_data[j]));
        check({name, "_last"}, 32'(outq[q0+j][8]), 32'(j == n_out - 1));
      end
    end
  endtask

  typedef struct packed {
    logic [3:0]  n;       // bytes to send, byte 0 in the top of 'bytes'
    logic [63:0] bytes;
    logic [3:0]  n_out;   // payload bytes expected, first in the top of 'outs'
    logic [31:0] outs;
    logic [1:0]  ok;
    logic [1:0]  err;
    logic [1:0]  code;
  } vec_t;

  vec_t       vecs[8];
  vec_t       v;
  logic [7:0] exp_data[16];
  int         ok0, err0, q0;
  logic [7:0] chk;

  initial begin
    vecs[0] = '{n:4'd6, bytes:64'hA5_03_11_22_33_03_00_00, n_out:4'd3, outs:32'h11_22_33_00, ok:2'd1, err:2'd0, code:2'd0};
    vecs[1] = '{n:4'd7, bytes:64'h00_FF_A5_02_AA_55_00_00, n_out:4'd0, outs:32'h0, ok:2'd0, err:2'd1, code:2'd2};
    vecs[2] = '{n:4'd2, bytes:64'hA5_00_00_00_00_00_00_00, n_out:4'd0, outs:32'h0, ok:2'd0, err:2'd1, code:2'd1};
    vecs[3] = '{n:4'd2, bytes:64'hA5_11_00_00_00_00_00_00, n_out:4'd0, outs:32'h0, ok:2'd0, err:2'd1, code:2'd1};
    vecs[4] = '{n:4'd4, bytes:64'hA5_01_7E_7F_00_00_00_00, n_out:4'd1, outs:32'h7E_00_00_00, ok:2'd1, err:2'd0, code:2'd1};
    vecs[5] = '{n:4'd2, bytes:64'hA5_A5_00_00_00_00_00_00, n_out:4'd0, outs:32'h0, ok:2'd0, err:2'd1, code:2'd1};
    vecs[6] = '{n:4'd5, bytes:64'hA5_02_AA_55_FD_00_00_00, n_out:4'd2, outs:32'hAA_55_00_00, ok:2'd1, err:2'd0, code:2'd1};
    vecs[7] = '{n:4'd5, bytes:64'h5A_A5_01_00_01_00_00_00, n_out:4'd1, outs:32'h00_00_00_00, ok:2'd1, err:2'd0, code:2'd1};

    // Reset state and release.
    #12;
    check("rst_s_ready", 32'(s_ready_o), 32'd0);
    check("rst_m_valid", 32'(m_valid_o), 32'd0);
    check("rst_m_last", 32'(m_last_o), 32'd0);
    check("rst_m_data", 32'(m_data_o), 32'd0);
    check("rst_pulses", 32'({pkt_ok_o, pkt_err_o}), 32'd0);
    check("rst_err_code", 32'(err_code_o), 32'd0);
    @(negedge clk_i);
    aresetn_i = 1'b1;
    #1;
    check("rel_s_ready_before_edge", 32'(s_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("rel_s_ready_after_edge", 32'(s_ready_o), 32'd1);

    // Table of whole frames, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      v    = vecs[i];
      ok0  = ok_cnt;
      err0 = err_cnt;
      q0   = outq.size();
      for (int k = 0; k < int'(v.n); k++) send(v.bytes[63-8*k -: 8]);
      if (v.ok != 2'd0) begin
        check($sformatf("v%0d_first_valid", i), 32'({pkt_ok_o, m_valid_o}), 32'd3);
        check($sformatf("v%0d_first_data", i), 32'(m_data_o), 32'(v.outs[31:24]));
      end else begin
        check($sformatf("v%0d_err_pulse", i), 32'(pkt_err_o), 32'(v.err));
      end
      repeat (8) @(posedge clk_i);
      #1;
      check($sformatf("v%0d_ok_pulses", i), 32'(ok_cnt - ok0), 32'(v.ok));
      check($sformatf("v%0d_err_pulses", i), 32'(err_cnt - err0), 32'(v.err));
      check($sformatf("v%0d_err_code", i), 32'(err_code_o), 32'(v.code));
      for (int j = 0; j < 4; j++) exp_data[j] = v.outs[31-8*j -: 8];
      check_outs($sformatf("v%0d_out", i), q0, int'(v.n_out), exp_data);
    end

    // Consumer stalls for five cycles during DRAIN.
    m_ready_i = 1'b0;
    ok0 = ok_cnt;
    q0  = outq.size();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    check("stall_first_valid", 32'({pkt_ok_o, m_valid_o}), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i);
      #1;
      check("stall_hold", 32'({m_valid_o, m_last_o, s_ready_o, m_data_o}), 32'h411);
    end
    m_ready_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
    check_outs("stall_out", q0, 3, exp_data);
    check("stall_ok_pulses", 32'(ok_cnt - ok0), 32'd1);
    check("stall_ready_back", 32'(s_ready_o), 32'd1);

    // Inter-byte timeout after exactly 50 idle clocks, then a clean frame.
    send(8'hA5); send(8'h02); send(8'h11);
    err0 = err_cnt;
    repeat (49) @(posedge clk_i);
    #1;
    check("tmo_not_yet", 32'(pkt_err_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("tmo_pulse", 32'(pkt_err_o), 32'd1);
    check("tmo_code", 32'(err_code_o), 32'd3);
    q0 = outq.size();
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    repeat (4) @(posedge clk_i);
    #1;
    exp_data[0] = 8'h7E;
    check_outs("tmo_next_out", q0, 1, exp_data);
    check("tmo_err_pulses", 32'(err_cnt - err0), 32'd1);

    // Reset after the second output byte aborts DRAIN at once.
    m_ready_i = 1'b0;
    ok0  = ok_cnt;
    err0 = err_cnt;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    m_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    m_ready_i = 1'b0;
    check("mid_drain_data", 32'({m_valid_o, m_data_o}), 32'h133);
    aresetn_i = 1'b0;
    #1;
    check("rst_abort_outputs", 32'({m_valid_o, m_last_o, s_ready_o, pkt_ok_o, pkt_err_o}), 32'd0);
    check("rst_abort_data", 32'(m_data_o), 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    aresetn_i = 1'b1;
    m_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_abort_code", 32'(err_code_o), 32'd0);
    q0 = outq.size();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    repeat (6) @(posedge clk_i);
    #1;
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
    check_outs("rst_next_out", q0, 3, exp_data);
    check("rst_ok_pulses", 32'(ok_cnt - ok0), 32'd2);
    check("rst_err_pulses", 32'(err_cnt - err0), 32'd0);

    // Maximum length frame, LEN = MAX_LEN = 16.
    q0  = outq.size();
    chk = 8'h10;
    send(8'hA5); send(8'h10);
    for (int k = 0; k < 16; k++) begin
      exp_data[k] = 8'(k * 7 + 3);
      chk ^= exp_data[k];
      send(exp_data[k]);
    end
    send(chk);
    check("max_first_valid", 32'({pkt_ok_o, m_valid_o}), 32'd3);
    repeat (20) @(posedge clk_i);
    #1;
    check_outs("max_out", q0, 16, exp_data);

    check("never_ok_and_err", 32'(both_cnt), 32'd0);
    check("no_stray_last", 32'(stray_last), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
